button_event_decoder: RTL and testbench

//  Sits directly downstream of the push-button debouncer. Its inputs are the debouncer's
//  one-cycle press pulse and the debounced button level.
//  It classifies each press as a single click, a double click or a long press.

---
 rtl/button_event_decoder_pkg.sv | 23 ++
 rtl/button_event_decoder_ms_tick_gen.sv | 34 +++
 rtl/button_event_decoder.sv | 144 ++++++++++++++
 tb/tb_button_event_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding and the
// default timing constants that are also used by the debouncer top.
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD1     = 3'd1,
    WAIT2     = 3'd2,
    HELD2     = 3'd3,
    LONG_HELD = 3'd4
  } btn_state_e;

  localparam int DEF_TICK_DIV  = 50000;
  localparam int DEF_LONG_MS   = 800;
  localparam int DEF_DBL_MS    = 300;
  localparam int DEF_REPEAT_MS = 150;
  localparam int DEF_CNT_W     = 12;

  function automatic logic state_is_busy(input btn_state_e s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/button_event_decoder_ms_tick_gen.sv
// 1 ms timebase prescaler: counts 0..TICK_DIV-1 and flags a tick on the wrap
// cycle. clr restarts the count so timeouts are measured from state entry.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = pre_q + PW'(1);
    if (clr || tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into single / double / long events.
// Optional auto-repeat while long-held is built when BTN_REPEAT_EN is defined.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int LONG_MS   = DEF_LONG_MS,
  parameter int DBL_MS    = DEF_DBL_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic press_pulse,
  input  logic btn_level,
  output logic single_o,
  output logic double_o,
  output logic long_o,
  output logic repeat_o,
  output logic busy
);

  if (LONG_MS >= 2**CNT_W || DBL_MS >= 2**CNT_W || REPEAT_MS >= 2**CNT_W ||
      REPEAT_MS < 1 || TICK_DIV < 1) begin : g_cfg_err
    $error("button_event_decoder: timing parameter out of range");
  end

  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] DBL_C   = CNT_W'(DBL_MS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] ms_q, ms_d;
  logic             tick;
  logic             clr;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_d;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_ms_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

`ifdef BTN_REPEAT_EN
  // Fires on the tick that would carry ms to REPEAT_MS, so the pulse lands
  // exactly REPEAT_MS ms after entry/previous repeat once registered.
  localparam logic [CNT_W-1:0] REP_PRE = CNT_W'(REPEAT_MS - 1);
  logic repeat_q;
`endif

  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_pulse) state_d = HELD1;
      end
      HELD1: begin
        if (!btn_level) begin
          state_d = WAIT2;
        end else if (ms_q == LONG_C) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      WAIT2: begin
        if (press_pulse) begin
          double_d = 1'b1;
          state_d  = HELD2;
        end else if (ms_q == DBL_C) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end
      end
      HELD2: begin
        if (!btn_level) state_d = IDLE;
      end
      LONG_HELD: begin
        if (!btn_level) begin
          state_d = IDLE;
        end
`ifdef BTN_REPEAT_EN
        else if (tick && ms_q == REP_PRE) begin
          repeat_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Every state change (and every repeat) restarts the whole timebase.
    clr  = (state_d != state_q) || repeat_d;
    ms_d = ms_q;
    if (clr) begin
      ms_d = '0;
    end else if (tick && ms_q != CNT_MAX) begin
      ms_d = ms_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ms_q     <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ms_q     <= ms_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end
  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign single_o = single_q;
  assign double_o = double_q;
  assign long_o   = long_q;
  assign busy     = state_is_busy(state_q);

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized gesture bench for button_event_decoder; expected event times are
// derived arithmetically from the click/double/long timing rules.
module tb_button_event_decoder;

  localparam int TD = 4;
  localparam int LM = 10;
  localparam int DM = 5;
  localparam int RM = 3;
  localparam int LONG_E = LM * TD + 1;
  localparam int DBL_E  = DM * TD + 1;
  localparam int REP_E  = RM * TD;

  localparam int K_SINGLE = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;
  localparam int K_REPEAT = 3;
  localparam int K_BRISE  = 4;
  localparam int K_BFALL  = 5;

  typedef struct {
    int e;
    int k;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic press_pulse;
  logic btn_level;
  logic single_o, double_o, long_o, repeat_o, busy;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   onehot_bad = 0;
  logic busy_prev = 1'b0;
  ev_t  log_q[$];
  ev_t  exp_q[$];

  button_event_decoder #(
    .TICK_DIV (TD),
    .LONG_MS  (LM),
    .DBL_MS   (DM),
    .REPEAT_MS(RM),
    .CNT_W    (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .press_pulse(press_pulse),
    .btn_level  (btn_level),
    .single_o   (single_o),
    .double_o   (double_o),
    .long_o     (long_o),
    .repeat_o   (repeat_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int e, input int k);
    ev_t v;
    v.e = e;
    v.k = k;
    return v;
  endfunction

  // Event recorder: cyc at a negedge is the index of the edge that produced the outputs.
  always @(negedge clk) begin
    if (single_o === 1'b1) log_q.push_back(mk(cyc, K_SINGLE));
    if (double_o === 1'b1) log_q.push_back(mk(cyc, K_DOUBLE));
    if (long_o === 1'b1)   log_q.push_back(mk(cyc, K_LONG));
    if (repeat_o === 1'b1) log_q.push_back(mk(cyc, K_REPEAT));
    if (busy === 1'b1 && busy_prev !== 1'b1) log_q.push_back(mk(cyc, K_BRISE));
    if (busy === 1'b0 && busy_prev === 1'b1) log_q.push_back(mk(cyc, K_BFALL));
    if ((int'(single_o === 1'b1) + int'(double_o === 1'b1) + int'(long_o === 1'b1) +
         int'(repeat_o === 1'b1)) > 1) onehot_bad <= onehot_bad + 1;
    busy_prev <= busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive_press(input int e);
    while (cyc < e - 1) @(negedge clk);
    press_pulse = 1'b1;
    btn_level   = 1'b1;
    @(negedge clk);
    press_pulse = 1'b0;
  endtask

  task automatic drive_level(input int e, input logic v);
    while (cyc < e - 1) @(negedge clk);
    btn_level = v;
  endtask

  // Reference: P press edge, R release edge, S second press edge (0 = none), R2 second release.
  function automatic int model(input int p, input int r, input int s, input int r2);
    int end_e;
    exp_q.delete();
    exp_q.push_back(mk(p, K_BRISE));
    if (r - p > LONG_E) begin
      exp_q.push_back(mk(p + LONG_E, K_LONG));
`ifdef BTN_REPEAT_EN
      for (int e = p + LONG_E + REP_E; e < r; e += REP_E) exp_q.push_back(mk(e, K_REPEAT));
`endif
      end_e = r;
    end else if (s > 0 && s - r <= DBL_E) begin
      exp_q.push_back(mk(s, K_DOUBLE));
      end_e = r2;
    end else begin
      exp_q.push_back(mk(r + DBL_E, K_SINGLE));
      end_e = r + DBL_E;
    end
    exp_q.push_back(mk(end_e, K_BFALL));
    return end_e;
  endfunction

  task automatic gesture(input int h, input int gap, input int h2, input int xtra);
    int p, r, s, r2, base, n, end_e;
    base = log_q.size();
    p = cyc + 1 + int'($urandom_range(1, 4));
    s = 0;
    r2 = 0;
    drive_press(p);
    r = p + h;
    if (xtra != 0 && h > LONG_E + 1) drive_press(p + LONG_E + 1);
    drive_level(r, 1'b0);
    if (gap > 0) begin
      s  = r + gap;
      r2 = s + h2;
      drive_press(s);
      if (xtra != 0 && h2 >= 2) drive_press(s + 1);
      drive_level(r2, 1'b0);
    end
    end_e = model(p, r, s, r2);
    while (cyc < end_e + 4) @(negedge clk);
    #1;
    n = log_q.size() - base;
    chk($sformatf("h%0d_g%0d_count", h, gap), n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk($sformatf("h%0d_g%0d_ev%0d_kind", h, gap, i), log_q[base+i].k, exp_q[i].k);
      chk($sformatf("h%0d_g%0d_ev%0d_edge", h, gap, i), log_q[base+i].e - p, exp_q[i].e - p);
    end
    chk("onehot", onehot_bad, 0);
  endtask

  initial begin
    int p, base, kind;
    rst = 1'b1;
    press_pulse = 1'b0;
    btn_level = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_single", single_o, 1'b0);
    chk("reset_double", double_o, 1'b0);
    chk("reset_long", long_o, 1'b0);
    chk("reset_repeat", repeat_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    gesture(3 * TD, 0, 0, 0);
    gesture(6, 2 * TD, 10, 0);
    gesture(25 * TD, 0, 0, 0);
    gesture(5, DBL_E, 7, 0);
    gesture(LONG_E, 0, 0, 0);
    gesture(LONG_E + 1, 0, 0, 0);
    gesture(1, 1, 1, 0);
    gesture(4, 3, 9, 1);
    gesture(90, 0, 0, 1);

    // Reset while in HELD1 drops the gesture entirely.
    p = cyc + 2;
    drive_press(p);
    while (cyc < p + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_single", single_o, 1'b0);
    chk("midrst_long", long_o, 1'b0);
    #1;
    base = log_q.size();
    drive_level(p + 10, 1'b0);
    while (cyc < p + 10 + LONG_E + DBL_E) @(negedge clk);
    #1;
    chk("midrst_no_events", log_q.size() - base, 0);

    for (int i = 0; i < 12; i++) begin
      kind = int'($urandom_range(0, 2));
      case (kind)
        0: gesture(int'($urandom_range(1, LONG_E)), 0, 0, 0);
        1: gesture(int'($urandom_range(1, LONG_E)), int'($urandom_range(1, DBL_E)),
                   int'($urandom_range(1, 30)), int'($urandom_range(0, 1)));
        default: gesture(int'($urandom_range(LONG_E + 1, 110)), 0, 0, int'($urandom_range(0, 1)));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
